// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 16;
  localparam int FETCH_DATA_WIDTH = 32;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries; flush empties it and wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head_entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       head_p0;
  logic [PTR_W-1:0]       tail_p0;
  logic [CNT_W-1:0]       count_p0;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_p0] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
    end else begin
      if (push) tail_p0 <= ptr_inc(tail_p0);
      if (pop)  head_p0 <= ptr_inc(head_p0);
      case ({push, pop})
        2'b10:   count_p0 <= count_p0 + CNT_W'(1);
        2'b01:   count_p0 <= count_p0 - CNT_W'(1);
        default: count_p0 <= count_p0;
      endcase
    end
  end

  assign head_entry = mem_q[head_p0];
  assign count      = count_p0;
  assign full       = (count_p0 == CNT_W'(DEPTH));
  assign empty      = (count_p0 == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, memory read issue and prefetch buffer glue.
// Optional FETCH_PERF_EN adds saturating stall/redirect counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           redirect_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc_p0;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  pop;
  logic                  issue;

  // A redirect hides the buffer head and blocks issue in the same cycle.
  assign out_valid = ~empty & ~redirect;
  assign pop       = out_valid & out_ready;
  assign issue     = rst_n & mem_grant & ~redirect & (~full | pop);

  assign mem_rd   = issue;
  assign mem_en   = issue;
  assign mem_wr   = 1'b0;
  assign mem_addr = pc_p0;

  assign push_entry = '{pc: pc_p0, instr: mem_rdata};
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;

  always_ff @(posedge clk) begin
    if (!rst_n)        pc_p0 <= RESET_PC;
    else if (redirect) pc_p0 <= redirect_pc;
    else if (issue)    pc_p0 <= pc_p0 + ADDR_WIDTH'(1);
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (issue),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  a_empty_cnt: assert property (@(posedge clk) disable iff (!rst_n) empty == (count == '0));
  a_full_cnt:  assert property (@(posedge clk) disable iff (!rst_n) full == (count == CNT_W'(DEPTH)));

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (!out_valid) stall_cycles   <= sat_inc(stall_cycles);
      if (redirect)   redirect_count <= sat_inc(redirect_count);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational word-addressed memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_grant;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_en;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;
`endif

  logic [31:0] mem [0:65535];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_grant   (mem_grant),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_en      (mem_en),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
`endif
  );

  function automatic logic [31:0] mem_word(input int a);
    return (a < 4) ? 32'(10 + a) : {16'hC0DE, 16'(a)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [15:0] pc);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_pc"},    64'(out_pc),    64'(pc));
    check_eq({tag, "_instr"}, 64'(out_instr), 64'(mem_word(int'(pc))));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = mem_word(i);
    rst_n = 1'b0; mem_grant = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    tick(); tick();

    // Reset state
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_rd",    64'(mem_rd),    64'd0);
    check_eq("rst_en",    64'(mem_en),    64'd0);
    check_eq("rst_wr",    64'(mem_wr),    64'd0);
    check_eq("rst_addr",  64'(mem_addr),  64'd0);

    // Streaming, one instruction per cycle
    rst_n = 1'b1; mem_grant = 1'b1; out_ready = 1'b1;
    #1;
    check_eq("s1_rd0",    64'(mem_rd),    64'd1);
    check_eq("s1_addr0",  64'(mem_addr),  64'd0);
    check_eq("s1_valid0", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head($sformatf("s1_head%0d", i), 16'(i));
    end

    // Backpressure fills the two-entry buffer, then drains in order
    rst_n = 1'b0; tick();
    rst_n = 1'b1; out_ready = 1'b0;
    #1;
    check_eq("s2_rd_a",   64'(mem_rd),   64'd1);
    check_eq("s2_addr_a", 64'(mem_addr), 64'd0);
    tick();
    check_eq("s2_rd_b",   64'(mem_rd),   64'd1);
    check_eq("s2_addr_b", 64'(mem_addr), 64'd1);
    tick();
    check_eq("s2_rd_full",   64'(mem_rd),   64'd0);
    check_eq("s2_addr_full", 64'(mem_addr), 64'd2);
    tick();
    check_eq("s2_rd_hold",   64'(mem_rd),   64'd0);
    check_eq("s2_addr_hold", 64'(mem_addr), 64'd2);
    check_head("s2_h0", 16'd0);
    out_ready = 1'b1;
    #1;
    check_eq("s2_rd_pop", 64'(mem_rd),   64'd1);
    check_eq("s2_addr_pop", 64'(mem_addr), 64'd2);
    tick(); check_head("s2_h1", 16'd1);
    tick(); check_head("s2_h2", 16'd2);

    // Redirect with a full buffer
    rst_n = 1'b0; tick();
    rst_n = 1'b1; out_ready = 1'b0;
    tick(); tick();
    check_eq("s3_full_valid", 64'(out_valid), 64'd1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    check_eq("s3_redir_valid", 64'(out_valid), 64'd0);
    check_eq("s3_redir_rd",    64'(mem_rd),    64'd0);
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("s3_bubble_valid", 64'(out_valid), 64'd0);
    check_eq("s3_tgt_rd",       64'(mem_rd),    64'd1);
    check_eq("s3_tgt_addr",     64'(mem_addr),  64'h40);
    tick(); check_head("s3_tgt", 16'h0040);

    // Back-to-back redirects: last one wins
    redirect = 1'b1; redirect_pc = 16'h0100; tick();
    redirect_pc = 16'h0200; tick();
    redirect = 1'b0;
    #1;
    check_eq("s3_b2b_addr", 64'(mem_addr), 64'h200);
    tick(); check_head("s3_b2b", 16'h0200);

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 16'hFFFF; tick();
    redirect = 1'b0;
    tick(); check_head("s4_ffff", 16'hFFFF);
    tick(); check_head("s4_0000", 16'h0000);
    tick(); check_head("s4_0001", 16'h0001);

    // Grant withdrawn for three cycles: drain, freeze, resume without skip
    mem_grant = 1'b0;
    #1;
    check_eq("s5_rd_g0",   64'(mem_rd),   64'd0);
    check_eq("s5_addr_g0", 64'(mem_addr), 64'd2);
    for (int i = 1; i < 3; i++) begin
      tick();
      check_eq($sformatf("s5_rd_g%0d", i),    64'(mem_rd),    64'd0);
      check_eq($sformatf("s5_addr_g%0d", i),  64'(mem_addr),  64'd2);
      check_eq($sformatf("s5_valid_g%0d", i), 64'(out_valid), 64'd0);
    end
    mem_grant = 1'b1;
    #1;
    check_eq("s5_resume_rd",   64'(mem_rd),   64'd1);
    check_eq("s5_resume_addr", 64'(mem_addr), 64'd2);
    tick(); check_head("s5_h2", 16'd2);
    tick(); check_head("s5_h3", 16'd3);

    // Reset dominates a simultaneous redirect
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    check_eq("s6_addr",  64'(mem_addr),  64'd0);
    check_eq("s6_valid", 64'(out_valid), 64'd0);
    check_eq("s6_rd",    64'(mem_rd),    64'd0);
`ifdef FETCH_PERF_EN
    check_eq("s6_stall_cnt", 64'(stall_cycles),   64'd0);
    check_eq("s6_redir_cnt", 64'(redirect_count), 64'd0);
`endif
    rst_n = 1'b1; redirect = 1'b0;
    #1;
    check_eq("s6_rel_addr", 64'(mem_addr), 64'd0);
    check_eq("s6_rel_rd",   64'(mem_rd),   64'd1);
    tick(); check_head("s6_h0", 16'd0);
`ifdef FETCH_PERF_EN
    check_eq("s6_stall_one", 64'(stall_cycles), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the word-addressed memory block `mem`.
- Owns the PC and issues read strobes to `mem`, using its `addr`, `rd`, `wr`, `en` and `out` ports.
- Captures returned words into a small prefetch buffer and presents {pc, instr} to decode with a valid/ready handshake.
- Supports branch redirect with flush, and yields the memory port when another master holds it.

Parameters:
- ADDR_WIDTH, 16, memory word-address width.
- DATA_WIDTH, 32, instruction/memory word width.
- DEPTH, 2, prefetch buffer entries; must be at least 1.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- mem_grant  in  1  fetch may use the memory port this cycle.
- mem_addr  out  ADDR_WIDTH  drives mem addr; equals current PC.
- mem_rd  out  1  read strobe to mem.
- mem_wr  out  1  tied 0.
- mem_en  out  1  equals mem_rd.
- mem_rdata  in  DATA_WIDTH  mem out; valid combinationally while mem_rd=1.
- redirect  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  ADDR_WIDTH  new PC when redirect=1.
- out_valid  out  1  head entry available.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  ADDR_WIDTH  address of the head instruction.
- out_instr  out  DATA_WIDTH  head instruction word.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc <= RESET_PC; buffer count <= 0.
  - out_valid=0, mem_rd=0, mem_en=0, mem_wr=0, mem_addr=RESET_PC.
  - Reset dominates redirect and all other inputs.
- Handshake:
  - pop = out_valid & out_ready.
  - out_valid = (count != 0) & ~redirect.
  - out_pc and out_instr hold stable while out_valid=1 and out_ready=0.
- Issue rule (combinational): issue = rst_n & mem_grant & ~redirect & ((count < DEPTH) | pop).
  - mem_rd = mem_en = issue.
  - mem_addr = pc at all times.
- On an issue edge:
  - Push {pc, mem_rdata} into the buffer.
  - pc <= pc + 1, modulo 2^ADDR_WIDTH, so 16'hFFFF wraps to 0.
- Latency: a word issued in cycle N is visible on out_* in cycle N+1. With continuous grant and ready, throughput is one instruction per cycle.
- Full buffer with a simultaneous pop: the push and pop both occur and count is unchanged. Full without a pop: no issue, and the PC holds.
- Empty buffer: out_valid=0; out_pc and out_instr are don't-care.
- mem_grant=0: no issue and the PC holds. The buffer still drains to decode.
- Redirect (highest priority after reset):
  - count <= 0 and pc <= redirect_pc.
  - No issue or pop that cycle.
  - The first fetch of the target occurs the next cycle, so the redirect bubble is 1 cycle plus 1-cycle latency.
  - Back-to-back redirects: the last one wins.
- Buffer: circular, with head/tail pointers wrapping at DEPTH. count ranges 0..DEPTH and has width clog2(DEPTH+1).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output ports stall_cycles[31:0] and redirect_count[31:0], both reset to 0.
  - stall_cycles increments each cycle where out_valid=0 and rst_n=1.
  - redirect_count increments per cycle with redirect=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - The ADDR_WIDTH and DATA_WIDTH default constants.
  - typedef struct packed fetch_entry_t {logic [ADDR_WIDTH-1:0] pc; logic [DATA_WIDTH-1:0] instr;}.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, full, empty and count. flush takes priority over push/pop.
- fetch_unit holds only the PC, the issue logic and the glue to fetch_fifo.

Test Plan:
- Reset then grant=1, ready=1, mem preloaded with addr 0..3 = 10,11,12,13 -> out_valid from cycle 2; out_pc 0,1,2,3 consecutive; out_instr 10,11,12,13.
- ready=0 with DEPTH=2 -> exactly 2 reads issued (pc 0,1), then mem_rd=0 and pc=2 holds. Raise ready -> entries 0,1 appear, then fetch resumes at 2.
- Redirect to 16'h0040 while the buffer holds 2 entries -> next cycle out_valid=0. The following cycle fetch addresses 0x40 and out_pc=0x40 with mem[0x40].
- Set pc near the top via redirect to 16'hFFFF -> sequence out_pc FFFF, 0000, 0001.
- mem_grant=0 for 3 cycles mid-stream -> no mem_rd and the PC frozen; the buffer drains; fetch resumes at the same PC with no skip or duplicate.
- Assert rst_n=0 mid-stream with redirect=1 -> next cycle pc=RESET_PC, out_valid=0. With FETCH_PERF_EN defined, both counters read 0.
